wb_regfile: RTL
===============

Name: wb_regfile

Overview:
Write-back end of the MEM-stage write interface. Captures the MEM stage's register-write triple (wdata, waddr, we) into a MEM/WB pipeline register, then commits it into the 32-entry general-purpose register file one cycle later. Serves two combinational read ports to the ID stage, with bypass from the in-flight write-back entry and, optionally, from the MEM stage.

Parameters:
DATA_W, 32, register and data width
ADDR_W, 5, register index width; the file holds 2**ADDR_W entries
MEM_FWD, 1, 1 = read ports also bypass from the MEM-stage inputs; 0 = bypass from the WB entry only

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset asserted)
mem_wdata_i  in  DATA_W  write data from the MEM stage
mem_waddr_i  in  ADDR_W  destination register from the MEM stage
mem_we_i  in  1  write enable from the MEM stage
stall_i  in  1  hold the WB pipeline register
flush_i  in  1  replace the WB entry with a bubble
re1_i  in  1  read-port-1 enable
raddr1_i  in  ADDR_W  read-port-1 index
rdata1_o  out  DATA_W  read-port-1 data
re2_i  in  1  read-port-2 enable
raddr2_i  in  ADDR_W  read-port-2 index
rdata2_o  out  DATA_W  read-port-2 data
wb_wdata_o  out  DATA_W  current WB entry data
wb_waddr_o  out  ADDR_W  current WB entry index
wb_we_o  out  1  current WB entry write enable

Behaviour:
- Reset (rst=0, asynchronous):
  - wb_wdata_o, wb_waddr_o and wb_we_o clear to 0 immediately.
  - All array entries clear to 0.
  - rdata1_o and rdata2_o read 0 while reset is held.
  - Reset deasserts synchronously to the design; the first capture happens at the first rising edge with rst=1.
- WB register update, on each rising edge:
  - flush_i=1: wb_we<=0; wb_waddr and wb_wdata <= 0.
  - else stall_i=1: hold all fields.
  - else: load mem_wdata_i, mem_waddr_i, mem_we_i.
  - flush takes priority over stall.
- Array commit, on each rising edge:
  - If wb_we=1 and wb_waddr!=0, array[wb_waddr] <= wb_wdata.
  - The commit uses the WB entry held before the edge, so it is not affected by a same-edge flush.
  - Under stall the same entry recommits on every edge. This is idempotent and required.
- Latency: MEM write presented in cycle N -> visible on wb_*_o in cycle N+1 -> in the array from cycle N+2.
  - Read bypass hides this latency: the value is readable from cycle N+1, or from cycle N if MEM_FWD=1.
- Read ports: combinational, identical per port, with priority in this order:
  1. re=0 -> 0.
  2. raddr=0 -> 0 (r0 is hardwired zero; writes to r0 are never stored or forwarded).
  3. MEM_FWD=1 and mem_we_i=1 and mem_waddr_i==raddr -> mem_wdata_i.
  4. wb_we=1 and wb_waddr==raddr -> wb_wdata.
  5. Otherwise -> array[raddr].
- Simultaneous events:
  - Both ports may read the same index.
  - A MEM and a WB write to the same index -> the MEM value wins on reads.
  - Array write and read of the same index in one cycle -> the read returns the bypassed new value, never the stale value.
- Reset mid-operation: the in-flight WB entry is discarded and not committed; the array clears.
- No X on any output after reset, including when the array is read with re=0.

Test Plan:
1. Reset: hold rst=0 and write-pulse mem_we_i=1, waddr=3 -> wb_*_o=0, rdata1_o=0; after release, reading r3 returns 0.
2. Basic write/read, MEM_FWD=0: cycle0 MEM writes r5=0xDEADBEEF ->
   - rdata1(r5)=0 in cycle0;
   - 0xDEADBEEF in cycle1 via WB bypass;
   - 0xDEADBEEF in cycle2+ from the array.
3. MEM bypass priority, MEM_FWD=1: WB holds r7=0x11, MEM presents r7=0x22 -> rdata1(r7)=0x22, rdata2(r7)=0x22. Next cycle -> 0x22.
4. r0 protection: MEM writes r0=0xFFFFFFFF -> wb_we_o=1, wb_waddr_o=0, rdata1(r0)=0 throughout; array r0 stays 0.
5. Stall/flush: WB holds r4=0xA5 with stall_i=1 for 3 cycles -> wb_*_o unchanged and r4 reads 0xA5. Then assert stall_i=1 and flush_i=1 together -> wb_we_o=0 on the next cycle and r4 still reads 0xA5 (already committed).
6. Async reset mid-write: r9=0x55 is in WB; pull rst low between clock edges -> wb_we_o=0 immediately; after release, r9 reads 0.

Source files
------------

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB pipeline register, 2**ADDR_W-entry register file, bypassed read ports
module wb_regfile #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter bit MEM_FWD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [ADDR_W-1:0] mem_waddr_i,
    input  logic              mem_we_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic [ADDR_W-1:0] wb_waddr_o,
    output logic              wb_we_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] wb_wdata;
    logic [ADDR_W-1:0] wb_waddr;
    logic              wb_we;
    logic [DATA_W-1:0] regs [DEPTH];

    logic              rd_en   [2];
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_wdata <= '0;
            wb_waddr <= '0;
            wb_we    <= 1'b0;
        end else if (flush_i) begin
            wb_wdata <= '0;
            wb_waddr <= '0;
            wb_we    <= 1'b0;
        end else if (!stall_i) begin
            wb_wdata <= mem_wdata_i;
            wb_waddr <= mem_waddr_i;
            wb_we    <= mem_we_i;
        end
    end

    // Commit uses the pre-edge WB entry, so a same-edge flush cannot cancel it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '{default: '0};
        end else if (wb_we && (wb_waddr != '0)) begin
            regs[wb_waddr] <= wb_wdata;
        end
    end

    assign rd_en[0]   = re1_i;
    assign rd_en[1]   = re2_i;
    assign rd_addr[0] = raddr1_i;
    assign rd_addr[1] = raddr2_i;

    // The MEM entry is younger than the WB entry, so it wins when both match.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            if (!rst || !rd_en[p] || (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
            end else if (MEM_FWD && mem_we_i && (mem_waddr_i == rd_addr[p])) begin
                rd_data[p] = mem_wdata_i;
            end else if (wb_we && (wb_waddr == rd_addr[p])) begin
                rd_data[p] = wb_wdata;
            end else begin
                rd_data[p] = regs[rd_addr[p]];
            end
        end
    end

    assign rdata1_o   = rd_data[0];
    assign rdata2_o   = rd_data[1];
    assign wb_wdata_o = wb_wdata;
    assign wb_waddr_o = wb_waddr;
    assign wb_we_o    = wb_we;

endmodule
